wb_sram_slave: RTL and testbench

Wishbone B3 responder holding a DEPTH-word on-chip memory. It sits on one slave port Sx[k] of the shared-bus interconnect. It handles classic single cycles with programmable wait states and registered-feedback incrementing bursts (linear, wrap4, wrap8 and wrap16). Writes are byte-lane enabled. Out-of-range word addresses are reported with err instead of ack.

---
 rtl/wb_sram_slave.sv | 158 +++++++++++++++
 tb/tb_wb_sram_slave.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_slave.sv
// Wishbone B3 slave backed by a DEPTH-word memory. It supports classic cycles with
// programmable wait states and registered-feedback bursts (linear and wrap4/8/16).
module wb_sram_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o
);

  localparam int LW = $clog2(DEPTH);
  localparam int BW = AW - 10;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_BURST = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [BW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [2:0]    cti_q, cti_d;
  logic [1:0]    bte_q, bte_d;

  logic [DW-1:0] mem_q [DEPTH];

  logic          req;
  logic          term;
  logic          oor;
  logic          ack;
  logic [LW-1:0] widx;
  logic          unused_adr;

  // The top address byte is decoded by the interconnect; bits [1:0] select bytes via sel.
  assign unused_adr = ^{wb_adr_i[AW-1:AW-8], wb_adr_i[1:0]};

  // Word address field covers everything below the decoded byte, so a linear
  // burst carrying past the top word raises oor instead of silently wrapping.
  function automatic logic [BW-1:0] next_addr(input logic [BW-1:0] a, input logic [1:0] bte);
    logic [BW-1:0] n;
    n = a;
    case (bte)
      2'b00:   n      = a + BW'(1);
      2'b01:   n[1:0] = a[1:0] + 2'd1;
      2'b10:   n[2:0] = a[2:0] + 3'd1;
      default: n[3:0] = a[3:0] + 4'd1;
    endcase
    return n;
  endfunction

  assign req  = wb_cyc_i & wb_stb_i;
  assign widx = addr_q[LW-1:0];
  assign oor  = |addr_q[BW-1:LW];

  always_comb begin
    term = 1'b0;
    case (state_q)
      S_RESP:  term = wb_cyc_i;
      S_BURST: term = req;
      default: term = 1'b0;
    endcase
  end

  assign ack      = term & ~oor;
  assign wb_ack_o = ack;
  assign wb_err_o = term & oor;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = ack ? mem_q[widx] : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    cti_d   = cti_q;
    bte_d   = bte_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = wb_adr_i[AW-9:2];
          we_d    = wb_we_i;
          cti_d   = wb_cti_i;
          bte_d   = wb_bte_i;
          cnt_d   = WS;
          state_d = (WS != 4'd0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!wb_cyc_i)          state_d = S_IDLE;
        else if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (wb_cyc_i && cti_q == 3'b010 && !oor) begin
          state_d = S_BURST;
          addr_d  = next_addr(addr_q, bte_q);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BURST: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (wb_stb_i) begin
          if (oor) begin
            state_d = S_IDLE;
          end else begin
            addr_d = next_addr(addr_q, bte_q);
            if (wb_cti_i == 3'b111) state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    addr_q <= addr_d;
    we_q   <= we_d;
    cti_q  <= cti_d;
    bte_q  <= bte_d;
  end

  always_ff @(posedge clk_i) begin
    if (ack && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem_q[widx][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: directed scenarios plus randomized classic and burst
// traffic, compared against a word-array reference model.
module tb_wb_sram_slave;

  localparam int WS    = 1;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;

  wb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS), .AW(32), .DW(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel), .wb_we_i(wb_we),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_cti_i(wb_cti), .wb_bte_i(wb_bte),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  logic [31:0] ref_mem [DEPTH];

  int          c_lat, c_nack, c_nerr;
  logic [31:0] c_rdat;

  logic [31:0] bdat_w [16];
  logic [3:0]  bsel_w [16];
  logic [31:0] bdat_r [16];
  int          b_acks, b_errs, b_gapack, b_dropack, b_span, b_gapped;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: word index arithmetic straight from the addressing rules.
  function automatic logic [21:0] nxt(input logic [21:0] w, input logic [1:0] bte);
    int size, base, off;
    if (bte == 2'b00) return w + 22'd1;
    size = 2 << bte;
    base = int'(w) - (int'(w) % size);
    off  = ((int'(w) % size) + 1) % size;
    return 22'(base + off);
  endfunction

  task automatic mwrite(input logic [21:0] w, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[w[9:0]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic classic(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = adr; wb_we = we; wb_dat = dat; wb_sel = sel;
    wb_cti = 3'b000; wb_bte = 2'b00;
    c_lat = -1; c_nack = 0; c_nerr = 0; c_rdat = '0;
    for (int c = 1; c <= 20 && c_lat < 0; c++) begin
      #2;
      if (wb_ack_o || wb_err_o) begin
        c_lat = c; c_rdat = wb_dat_o;
        c_nack += int'(wb_ack_o); c_nerr += int'(wb_err_o);
      end
      next_cycle();
    end
    // Request still held for one more cycle: no further termination may appear.
    #2;
    c_nack += int'(wb_ack_o); c_nerr += int'(wb_err_o);
    next_cycle();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    next_cycle();
  endtask

  task automatic classic_model(input string tag, input logic [31:0] adr, input logic we,
                               input logic [31:0] dat, input logic [3:0] sel);
    logic [21:0] w;
    w = adr[23:2];
    classic(adr, we, dat, sel);
    chk({tag, " latency"}, 32'(c_lat), 32'(2 + WS));
    if (w >= 22'(DEPTH)) begin
      chk({tag, " err count"}, 32'(c_nerr), 32'd1);
      chk({tag, " ack count"}, 32'(c_nack), 32'd0);
    end else begin
      chk({tag, " ack count"}, 32'(c_nack), 32'd1);
      chk({tag, " err count"}, 32'(c_nerr), 32'd0);
      if (we) mwrite(w, dat, sel);
      else    chk({tag, " rdata"}, c_rdat, ref_mem[w[9:0]]);
    end
  endtask

  task automatic burst(input logic [31:0] adr, input logic we, input logic [1:0] bte,
                       input int n, input int gap_after, input int abort_after);
    int beat, first_c, last_c;
    bit done;
    b_acks = 0; b_errs = 0; b_gapack = 0; b_dropack = 0; b_gapped = 0;
    beat = 0; first_c = -1; last_c = -1; done = 1'b0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = adr; wb_we = we; wb_bte = bte;
    wb_cti = (n == 1) ? 3'b111 : 3'b010; wb_dat = bdat_w[0]; wb_sel = bsel_w[0];
    for (int c = 0; c < 80 && !done; c++) begin
      #2;
      if (wb_stb && (wb_ack_o || wb_err_o)) begin
        bdat_r[beat] = wb_dat_o;
        if (wb_err_o) begin b_errs++; done = 1'b1; end
        else b_acks++;
        if (first_c < 0) first_c = c;
        last_c = c;
        beat++;
        if (beat == n) done = 1'b1;
      end else if (!wb_stb && (wb_ack_o || wb_err_o)) begin
        b_gapack++;
      end
      next_cycle();
      if (!done) begin
        wb_adr = $urandom;
        if (abort_after >= 0 && beat == abort_after) begin
          wb_cyc = 1'b0; wb_stb = 1'b1; wb_dat = bdat_w[beat]; wb_sel = 4'hF;
          #2;
          if (wb_ack_o || wb_err_o) b_dropack++;
          next_cycle();
          done = 1'b1;
        end else if (beat == gap_after && b_gapped == 0) begin
          wb_stb = 1'b0; b_gapped = 1;
        end else begin
          wb_stb = 1'b1; wb_cti = (beat == n - 1) ? 3'b111 : 3'b010;
          wb_dat = bdat_w[beat]; wb_sel = bsel_w[beat];
        end
      end
    end
    b_span = last_c - first_c;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_cti = 3'b000;
    next_cycle();
  endtask

  // Walks the burst through the model: expected beat count, error beat, data.
  task automatic model_burst(input string tag, input logic [31:0] adr, input logic we,
                             input logic [1:0] bte, input int n);
    logic [21:0] w;
    int exp_acks, exp_errs;
    w = adr[23:2]; exp_acks = 0; exp_errs = 0;
    for (int i = 0; i < n && exp_errs == 0; i++) begin
      if (w >= 22'(DEPTH)) begin
        exp_errs = 1;
      end else begin
        if (i < b_acks) begin
          if (we) mwrite(w, bdat_w[i], bsel_w[i]);
          else    chk($sformatf("%s beat%0d", tag, i), bdat_r[i], ref_mem[w[9:0]]);
        end
        exp_acks++;
        w = nxt(w, bte);
      end
    end
    chk({tag, " acks"}, 32'(b_acks), 32'(exp_acks));
    chk({tag, " errs"}, 32'(b_errs), 32'(exp_errs));
  endtask

  initial begin
    logic [31:0] a, d;
    int n, w, g;
    logic [1:0] bt;
    logic we;

    rst = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = 32'h9000_0010; wb_dat = '0;
    wb_sel = 4'hF; wb_we = 1'b0; wb_cti = 3'b000; wb_bte = 2'b00;
    next_cycle();
    next_cycle();
    #2;
    chk("reset ack", 32'(wb_ack_o), 32'd0);
    chk("reset err", 32'(wb_err_o), 32'd0);
    chk("reset dat", wb_dat_o, 32'd0);
    chk("rty const", 32'(wb_rty_o), 32'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();

    // Fill the whole memory with 16-beat linear write bursts.
    for (int k = 0; k < DEPTH / 16; k++) begin
      for (int i = 0; i < 16; i++) begin bdat_w[i] = $urandom; bsel_w[i] = 4'hF; end
      a = 32'h9000_0000 | 32'(k * 64);
      burst(a, 1'b1, 2'b00, 16, -1, -1);
      model_burst($sformatf("init%0d", k), a, 1'b1, 2'b00, 16);
    end

    // Classic write then read with wait states.
    classic_model("t1 write", 32'h9000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF);
    classic_model("t1 read", 32'h9000_0010, 1'b0, 32'h0, 4'hF);
    chk("t1 read const", c_rdat, 32'hDEAD_BEEF);

    // Byte lane write.
    classic_model("t2 byte write", 32'h9000_0010, 1'b1, 32'h0000_1200, 4'b0010);
    classic_model("t2 read", 32'h9000_0010, 1'b0, 32'h0, 4'hF);
    chk("t2 read const", c_rdat, 32'hDEAD_12EF);

    // Linear 4-beat write burst, then read back.
    for (int i = 0; i < 4; i++) begin bdat_w[i] = 32'(i + 1); bsel_w[i] = 4'hF; end
    burst(32'h9000_0020, 1'b1, 2'b00, 4, -1, -1);
    model_burst("t3 wr", 32'h9000_0020, 1'b1, 2'b00, 4);
    chk("t3 wr span", 32'(b_span), 32'd3);
    burst(32'h9000_0020, 1'b0, 2'b00, 4, -1, -1);
    model_burst("t3 rd", 32'h9000_0020, 1'b0, 2'b00, 4);
    chk("t3 rd span", 32'(b_span), 32'd3);
    for (int i = 0; i < 4; i++) chk($sformatf("t3 const%0d", i), bdat_r[i], 32'(i + 1));
    classic_model("t3 idle after", 32'h9000_0024, 1'b0, 32'h0, 4'hF);

    // Wrap4 read from word 6 with a master wait state after beat 2.
    burst(32'h9000_0018, 1'b0, 2'b01, 4, 2, -1);
    model_burst("t4 wrap4", 32'h9000_0018, 1'b0, 2'b01, 4);
    chk("t4 word4 third", bdat_r[2], ref_mem[4]);
    chk("t4 word5 fourth", bdat_r[3], ref_mem[5]);
    chk("t4 gap ack", 32'(b_gapack), 32'd0);
    chk("t4 span", 32'(b_span), 32'd4);

    // Out-of-range classic access and a linear burst running off the top.
    classic_model("t5 oor classic", 32'h9000_1000, 1'b0, 32'h0, 4'hF);
    burst(32'h9000_0FFC, 1'b0, 2'b00, 4, -1, -1);
    model_burst("t5 oor burst", 32'h9000_0FFC, 1'b0, 2'b00, 4);
    classic_model("t5 idle after", 32'h9000_0FFC, 1'b0, 32'h0, 4'hF);

    // Reset during the wait state.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h9000_0010; wb_cti = 3'b000;
    next_cycle();
    rst = 1'b0;
    #2;
    chk("t6 rst ack", 32'(wb_ack_o), 32'd0);
    chk("t6 rst dat", wb_dat_o, 32'd0);
    next_cycle();
    rst = 1'b1;
    #2;
    chk("t6 post-rst ack", 32'(wb_ack_o), 32'd0);
    chk("t6 post-rst err", 32'(wb_err_o), 32'd0);
    chk("t6 post-rst dat", wb_dat_o, 32'd0);
    next_cycle();
    wb_cyc = 1'b0; wb_stb = 1'b0;
    next_cycle();
    classic_model("t6 read after rst", 32'h9000_0010, 1'b0, 32'h0, 4'hF);

    // Abort a write burst after two beats.
    for (int i = 0; i < 4; i++) begin bdat_w[i] = $urandom; bsel_w[i] = 4'hF; end
    burst(32'h9000_00A0, 1'b1, 2'b00, 4, -1, 2);
    model_burst("t6 abort", 32'h9000_00A0, 1'b1, 2'b00, 2);
    chk("t6 drop ack", 32'(b_dropack), 32'd0);
    for (int i = 0; i < 4; i++)
      classic_model($sformatf("t6 abort rd%0d", i), 32'h9000_00A0 + 32'(4 * i), 1'b0, 32'h0, 4'hF);

    // Random classic traffic, including out-of-range words and junk top/low bits.
    for (int k = 0; k < 24; k++) begin
      w = $urandom_range(0, 2 * DEPTH - 1);
      a = ($urandom & 32'hFF00_0000) | 32'(w << 2) | ($urandom & 32'h3);
      we = 1'($urandom);
      classic_model($sformatf("rnd classic%0d", k), a, we, $urandom, 4'($urandom));
    end

    // Random bursts of every type, random length and an occasional master wait state.
    for (int k = 0; k < 16; k++) begin
      n = $urandom_range(1, 16);
      bt = 2'($urandom);
      we = 1'($urandom);
      g = (n > 1) ? $urandom_range(1, n - 1) : -1;
      w = $urandom_range(0, DEPTH - 1);
      a = 32'h9000_0000 | 32'(w << 2);
      for (int i = 0; i < 16; i++) begin bdat_w[i] = $urandom; bsel_w[i] = 4'($urandom); end
      burst(a, we, bt, n, g, -1);
      model_burst($sformatf("rnd burst%0d", k), a, we, bt, n);
      chk($sformatf("rnd burst%0d gap", k), 32'(b_gapack), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
